// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, reads the boot ROM and holds one fetched entry for decode.
// Optional build macro IFETCH_BSWAP_EN byte-swaps ROM words (big-endian image -> little-endian order).
module ifetch #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ROM_COL_MAX = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_fault
);

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } entry_t;

   localparam logic [31:0] PC_LIMIT = 32'(4 * ROM_COL_MAX);

   function automatic logic [31:0] swap(input logic [31:0] d);
`ifdef IFETCH_BSWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        vld_q, vld_d;
   entry_t      ent_q, ent_d;
   logic        pc_ok, load;

   assign pc_ok = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);
   // A redirect always wins over a load; decode may still take the old entry that cycle.
   assign load  = (state_q == RUN) && !redirect_valid && (!vld_q || if_ready);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      vld_d   = vld_q;
      ent_d   = ent_q;
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         vld_d   = 1'b0;
         state_d = RUN;
      end else begin
         case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
               if (load) begin
                  vld_d = 1'b1;
                  if (pc_ok) begin
                     ent_d = '{pc: pc_q, instr: swap(rom_data), fault: 1'b0};
                     pc_d  = pc_q + 32'd4;
                  end else begin
                     ent_d   = '{pc: pc_q, instr: 32'h0, fault: 1'b1};
                     state_d = FAULT;
                  end
               end
            end
            // Halted: the fault entry drains, then nothing more until a redirect.
            FAULT: if (vld_q && if_ready) vld_d = 1'b0;
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         vld_q   <= 1'b0;
         ent_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         vld_q   <= vld_d;
         ent_q   <= ent_d;
      end
   end

   assign rom_addr = pc_q;
   assign if_valid = vld_q;
   assign if_pc    = ent_q.pc;
   assign if_instr = ent_q.instr;
   assign if_fault = ent_q.fault;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized ready/redirect traffic
// compared against a transaction-level model of the fetch buffer.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rom_addr, rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid, if_ready, if_fault;
   logic [31:0] if_pc, if_instr;

   int checks = 0;
   int failures = 0;

   logic [31:0] rom [32];

   always #5 clk = ~clk;

   assign rom_data = (rom_addr < 32'd128) ? rom[rom_addr[6:2]] : 32'hBAD0_BAD0;

   ifetch #(.RESET_PC(32'h0), .ROM_COL_MAX(32)) dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
      .if_instr(if_instr), .if_fault(if_fault)
   );

   // Reference model: fetch pointer, boot/halt flags and the single buffered entry.
   logic [31:0] m_pc, m_ipc, m_instr;
   logic        m_boot, m_halt, m_v, m_fault;

   function automatic logic [31:0] ref_swap(input logic [31:0] d);
`ifdef IFETCH_BSWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_boot = 1'b1; m_halt = 1'b0;
      m_v = 1'b0; m_ipc = 32'h0; m_instr = 32'h0; m_fault = 1'b0;
   endtask

   task automatic model_advance();
      if (m_boot) begin
         m_boot = 1'b0;
         if (redirect_valid) m_pc = redirect_pc;
      end else if (redirect_valid) begin
         m_pc = redirect_pc; m_v = 1'b0; m_halt = 1'b0;
      end else if (!m_halt && (!m_v || if_ready)) begin
         m_v = 1'b1; m_ipc = m_pc;
         if (m_pc % 4 == 0 && m_pc < 128) begin
            m_instr = ref_swap(rom[m_pc / 4]); m_fault = 1'b0; m_pc = m_pc + 4;
         end else begin
            m_instr = 32'h0; m_fault = 1'b1; m_halt = 1'b1;
         end
      end else if (m_v && if_ready) begin
         m_v = 1'b0;
      end
   endtask

   task automatic compare();
      check("rom_addr", rom_addr, m_pc);
      check("if_valid", 32'(if_valid), 32'(m_v));
      if (m_v) begin
         check("if_pc", if_pc, m_ipc);
         check("if_instr", if_instr, m_instr);
         check("if_fault", 32'(if_fault), 32'(m_fault));
      end
   endtask

   task automatic step();
      model_advance();
      @(posedge clk); #1;
      compare();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 32'(if_valid), 32'h0);
      check({tag, "_pc"}, if_pc, 32'h0);
      check({tag, "_instr"}, if_instr, 32'h0);
      check({tag, "_fault"}, 32'(if_fault), 32'h0);
      check({tag, "_addr"}, rom_addr, 32'h0);
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_valid = 1'b1; redirect_pc = target;
      step();
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = $urandom;
      rom[0] = 32'h0000_0013; rom[1] = 32'h0010_0093; rom[2] = 32'h0020_0113;
      rst_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      model_reset();
      #3;
      check_reset_state("reset");
      @(posedge clk); #1;
      rst_n = 1'b1; if_ready = 1'b1;

      // Boot cycle, then back-to-back entries
      step();
      check("boot_no_entry", 32'(if_valid), 32'h0);
      step();
      check("first_valid", 32'(if_valid), 32'h1);
      check("first_pc", if_pc, 32'h0);
      check("first_instr", if_instr, ref_swap(32'h0000_0013));
      step();
      check("second_pc", if_pc, 32'h4);

      // Stall with if_ready low
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_pc", if_pc, 32'h4);
         check("stall_instr", if_instr, ref_swap(32'h0010_0093));
      end
      if_ready = 1'b1;
      step();
      check("after_stall_pc", if_pc, 32'h8);

      // Redirect flushes, target arrives one cycle later
      redirect_to(32'h10);
      check("redir_flush", 32'(if_valid), 32'h0);
      step();
      check("redir_target_pc", if_pc, 32'h10);
      check("redir_target_instr", if_instr, ref_swap(rom[4]));

      // Misaligned target -> fault entry, then halt
      redirect_to(32'h6);
      step();
      check("mis_fault", 32'(if_fault), 32'h1);
      check("mis_pc", if_pc, 32'h6);
      check("mis_instr", if_instr, 32'h0);
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         check("halt_idle", 32'(if_valid), 32'h0);
      end
      redirect_to(32'h0);
      step();
      check("resume_pc", if_pc, 32'h0);

      // Walk off the end of the ROM
      redirect_to(32'h78);
      step(); step();
      check("last_pc", if_pc, 32'h7C);
      check("last_fault", 32'(if_fault), 32'h0);
      step();
      check("oob_pc", if_pc, 32'h80);
      check("oob_fault", 32'(if_fault), 32'h1);
      step(); step();
      check("oob_pc_hold", rom_addr, 32'h80);

      // Byte-order build check
      rom[0] = 32'h1300_0000;
      redirect_to(32'h0);
      step();
`ifdef IFETCH_BSWAP_EN
      check("bswap_instr", if_instr, 32'h0000_0013);
`else
      check("bswap_instr", if_instr, 32'h1300_0000);
`endif

      // Randomized traffic with one asynchronous reset mid-run
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            check_reset_state("midreset");
            @(posedge clk); #1;
            check_reset_state("midreset_hold");
            rst_n = 1'b1;
         end
         if_ready = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 4))
            0: redirect_pc = 32'(($urandom_range(0, 31)) * 4);
            1: redirect_pc = 32'h78 + 32'($urandom_range(0, 3) * 4);
            2: redirect_pc = 32'($urandom_range(0, 127));
            3: redirect_pc = $urandom;
            default: redirect_pc = 32'(($urandom_range(24, 31)) * 4);
         endcase
         step();
      end
      redirect_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
